// File: rtl/fmap_stream_tx_pkg.sv
// -----------------------------------------------------------------------------
// fmap_tx_pkg
// Shared types and helpers for the feature-map stream transmitter.
//   state_t       : transmitter FSM states
//   width_of()    : bits needed to hold the values 0 .. value-1 (at least 1)
//   max_int()     : larger of two integers, for sizing shared counters
//   row_beats()   : read beats in one row (SIZE * CHANNEL)
//   REPEAT_W      : width of the frame repeat count / frame counter
//   DELAY_FIELDS  : number of framing bits carried through the delay line
// -----------------------------------------------------------------------------
package fmap_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_PAD,
    ST_HSYNC,
    ST_ROW,
    ST_GAP,
    ST_DRAIN
  } state_t;

  localparam int REPEAT_W     = 8;
  localparam int DELAY_FIELDS = 5;  // {vsync, hsync, reuse, valid, done}

  function automatic int width_of(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int row_beats(input int size, input int channel);
    return size * channel;
  endfunction

endpackage

// File: rtl/fmap_stream_tx_if.sv
// -----------------------------------------------------------------------------
// fmap_stream_tx_if
// Control, buffer-read and framed-stream signals of fmap_stream_tx.
//   master : the transmitter (drives busy/done, read port, stream)
//   slave  : the environment (drives start/repeat and the read data)
// -----------------------------------------------------------------------------
interface fmap_stream_tx_if
  import fmap_tx_pkg::*;
#(
  parameter int WIDTH_D = 27,
  parameter int AW      = 16
);
  logic                i_start;
  logic [REPEAT_W-1:0] i_repeat;
  logic                o_busy;
  logic                o_done;
  logic                o_rden;
  logic [AW-1:0]       o_raddr;
  logic [WIDTH_D-1:0]  i_rdata;
  logic                o_vsync;
  logic                o_hsync;
  logic                o_reuse;
  logic                o_valid;
  logic [WIDTH_D-1:0]  o_tdata;

  modport master (
    input  i_start, i_repeat, i_rdata,
    output o_busy, o_done, o_rden, o_raddr,
           o_vsync, o_hsync, o_reuse, o_valid, o_tdata
  );

  modport slave (
    output i_start, i_repeat, i_rdata,
    input  o_busy, o_done, o_rden, o_raddr,
           o_vsync, o_hsync, o_reuse, o_valid, o_tdata
  );
endinterface

// File: rtl/fmap_stream_tx_delay_line.sv
// -----------------------------------------------------------------------------
// stream_delay_line
// DEPTH-stage shift register with asynchronous active-high clear.
//   i_sclk : clock
//   i_rst  : asynchronous clear of every stage
//   din    : WIDTH-bit input
//   dout   : din delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module stream_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             i_sclk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [WIDTH-1:0] q_reg;
    if (gi == 0) begin : g_first
      always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) q_reg <= '0;
        else       q_reg <= din;
      end
    end else begin : g_next
      always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) q_reg <= '0;
        else       q_reg <= g_stage[gi-1].q_reg;
      end
    end
  end

  assign dout = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/fmap_stream_tx.sv
// -----------------------------------------------------------------------------
// fmap_stream_tx
// Reads a SIZE x SIZE x CHANNEL feature map from a buffer (channel fastest)
// and emits it as a vsync/hsync/reuse/valid/tdata framed stream, replaying
// the frame i_repeat times (0 counts as 1).
//   i_sclk          : clock
//   i_rst           : asynchronous active-high reset
//   bus.i_start     : start request, honoured in IDLE only
//   bus.i_repeat    : frames to emit, latched on accepted start
//   bus.o_busy      : accepted start .. o_done inclusive
//   bus.o_done      : pulse with the final beat of the final frame
//   bus.o_rden/o_raddr/i_rdata : buffer read port, RD_LAT cycles latency
//   bus.o_vsync/o_hsync/o_reuse/o_valid/o_tdata : framed output stream
// -----------------------------------------------------------------------------
module fmap_stream_tx
  import fmap_tx_pkg::*;
#(
  parameter int WIDTH_D   = 27,
  parameter int SIZE      = 14,
  parameter int CHANNEL   = 256,
  parameter int GAP       = 4,
  parameter int VSYNC_LEN = 8,
  parameter int PADWAIT   = 21,
  parameter int RD_LAT    = 2,
  parameter int AW        = $clog2(SIZE*SIZE*CHANNEL)
) (
  input logic              i_sclk,
  input logic              i_rst,
  fmap_stream_tx_if.master bus
);

  localparam int ROW_BEATS   = row_beats(SIZE, CHANNEL);
  localparam int FRAME_BEATS = SIZE * ROW_BEATS;
  localparam int CNT_MAX     = max_int(max_int(max_int(VSYNC_LEN, PADWAIT),
                                               max_int(ROW_BEATS, GAP)), RD_LAT);
  localparam int CW          = width_of(CNT_MAX);
  localparam int RW          = width_of(SIZE);

  // Terminal counts per state; zero-length states are never entered, so
  // their terminal count is clamped just to keep the constant legal.
  localparam logic [CW-1:0] VSYNC_LAST = CW'(VSYNC_LEN - 1);
  localparam logic [CW-1:0] PAD_LAST   = CW'(max_int(PADWAIT, 1) - 1);
  localparam logic [CW-1:0] ROW_LAST   = CW'(ROW_BEATS - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(max_int(GAP, 1) - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(RD_LAT - 1);
  localparam logic [RW-1:0] LAST_ROW   = RW'(SIZE - 1);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(FRAME_BEATS - 1);

  state_t              state_reg, state_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic [RW-1:0]       row_reg, row_next;
  logic [AW-1:0]       addr_reg, addr_next;
  logic [REPEAT_W-1:0] frame_reg, frame_next;
  logic [REPEAT_W-1:0] rep_reg, rep_next;
  logic                busy_reg, busy_next;

  logic                row_end;
  logic                last_row, last_frame;
  logic                vsync_int, hsync_int, reuse_int, valid_int, done_int;
  logic [DELAY_FIELDS-1:0] dly_out;

  logic                vsync_reg, hsync_reg, reuse_reg, valid_reg, done_reg;
  logic [WIDTH_D-1:0]  tdata_reg;

  assign last_row   = (row_reg == LAST_ROW);
  assign last_frame = (frame_reg >= rep_reg);

  always_ff @(posedge i_sclk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      row_reg   <= '0;
      addr_reg  <= '0;
      frame_reg <= '0;
      rep_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      row_reg   <= row_next;
      addr_reg  <= addr_next;
      frame_reg <= frame_next;
      rep_reg   <= rep_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    row_next   = row_reg;
    addr_next  = addr_reg;
    frame_next = frame_reg;
    rep_next   = rep_reg;
    busy_next  = busy_reg;
    row_end    = 1'b0;

    // busy drops the cycle after the done pulse leaves the output register
    if (done_reg) busy_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (bus.i_start) begin
          state_next = ST_VSYNC;
          rep_next   = (bus.i_repeat == '0) ? REPEAT_W'(1) : bus.i_repeat;
          frame_next = REPEAT_W'(1);
          row_next   = '0;
          addr_next  = '0;
          busy_next  = 1'b1;
        end
      end
      ST_VSYNC: begin
        if (cnt_reg == VSYNC_LAST) begin
          cnt_next   = '0;
          state_next = (PADWAIT > 0) ? ST_PAD : ST_HSYNC;
        end
      end
      ST_PAD: begin
        if (cnt_reg == PAD_LAST) begin
          cnt_next   = '0;
          state_next = ST_HSYNC;
        end
      end
      ST_HSYNC: begin
        cnt_next   = '0;
        state_next = ST_ROW;
      end
      ST_ROW: begin
        // address runs contiguously across rows, wrapping only at frame end
        addr_next = (addr_reg == LAST_ADDR) ? '0 : addr_reg + 1'b1;
        if (cnt_reg == ROW_LAST) begin
          cnt_next = '0;
          if (GAP > 0) state_next = ST_GAP;
          else         row_end    = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          cnt_next = '0;
          row_end  = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_reg == DRAIN_LAST) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase

    if (row_end) begin
      if (!last_row) begin
        row_next   = row_reg + 1'b1;
        state_next = ST_HSYNC;
      end else if (!last_frame) begin
        frame_next = frame_reg + 1'b1;
        row_next   = '0;
        addr_next  = '0;
        state_next = ST_VSYNC;
      end else begin
        state_next = ST_DRAIN;
      end
    end
  end

  // Framing generated at read-issue time, aligned to i_rdata below.
  assign vsync_int = (state_reg == ST_VSYNC);
  assign hsync_int = (state_reg == ST_HSYNC);
  assign valid_int = (state_reg == ST_ROW);
  assign done_int  = valid_int && (cnt_reg == ROW_LAST) && last_row && last_frame;
  // Replays keep reuse up from vsync through their last beat; the trailing
  // gap of the final frame is not part of any emitted data.
  assign reuse_int = (frame_reg > REPEAT_W'(1)) &&
                     ((state_reg == ST_VSYNC) || (state_reg == ST_PAD) ||
                      (state_reg == ST_HSYNC) || (state_reg == ST_ROW) ||
                      ((state_reg == ST_GAP) && !(last_row && last_frame)));

  stream_delay_line #(
    .DEPTH (RD_LAT),
    .WIDTH (DELAY_FIELDS)
  ) u_align (
    .i_sclk (i_sclk),
    .i_rst  (i_rst),
    .din    ({vsync_int, hsync_int, reuse_int, valid_int, done_int}),
    .dout   (dly_out)
  );

  always_ff @(posedge i_sclk or posedge i_rst) begin
    if (i_rst) begin
      vsync_reg <= 1'b0;
      hsync_reg <= 1'b0;
      reuse_reg <= 1'b0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
      tdata_reg <= '0;
    end else begin
      vsync_reg <= dly_out[4];
      hsync_reg <= dly_out[3];
      reuse_reg <= dly_out[2];
      valid_reg <= dly_out[1];
      done_reg  <= dly_out[0];
      tdata_reg <= dly_out[1] ? bus.i_rdata : '0;
    end
  end

  assign bus.o_busy  = busy_reg;
  assign bus.o_done  = done_reg;
  assign bus.o_rden  = (state_reg == ST_ROW);
  assign bus.o_raddr = addr_reg;
  assign bus.o_vsync = vsync_reg;
  assign bus.o_hsync = hsync_reg;
  assign bus.o_reuse = reuse_reg;
  assign bus.o_valid = valid_reg;
  assign bus.o_tdata = tdata_reg;

endmodule

// File: tb/tb_fmap_stream_tx.sv
// -----------------------------------------------------------------------------
// tb_fmap_stream_tx
// Two transmitters on one clock: A with GAP=2/PADWAIT=3, B with GAP=0/
// PADWAIT=0. Each buffer returns addr+100 two cycles after the read.
// Expected traces come from frame arithmetic (position inside the frame),
// not from any model of the state machine.
// -----------------------------------------------------------------------------
module tb_fmap_stream_tx;

  localparam int WD   = 27;
  localparam int S    = 3;
  localparam int C    = 2;
  localparam int VL   = 2;
  localparam int RL   = 2;
  localparam int GAPA = 2;
  localparam int PWA  = 3;
  localparam int GAPB = 0;
  localparam int PWB  = 0;
  localparam int AW   = $clog2(S*S*C);
  localparam int OW   = 7 + AW + WD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int sel      = 0;

  fmap_stream_tx_if #(.WIDTH_D(WD), .AW(AW)) bus_a ();
  fmap_stream_tx_if #(.WIDTH_D(WD), .AW(AW)) bus_b ();

  fmap_stream_tx #(
    .WIDTH_D(WD), .SIZE(S), .CHANNEL(C), .GAP(GAPA), .VSYNC_LEN(VL),
    .PADWAIT(PWA), .RD_LAT(RL), .AW(AW)
  ) dut_a (
    .i_sclk (clk),
    .i_rst  (rst),
    .bus    (bus_a)
  );

  fmap_stream_tx #(
    .WIDTH_D(WD), .SIZE(S), .CHANNEL(C), .GAP(GAPB), .VSYNC_LEN(VL),
    .PADWAIT(PWB), .RD_LAT(RL), .AW(AW)
  ) dut_b (
    .i_sclk (clk),
    .i_rst  (rst),
    .bus    (bus_b)
  );

  // Buffer models: two-cycle read latency, data = address + 100.
  logic [AW-1:0] pa1, pa2, pb1, pb2;
  always @(posedge clk) begin
    pa1 <= bus_a.o_raddr;
    pa2 <= pa1;
    pb1 <= bus_b.o_raddr;
    pb2 <= pb1;
  end
  assign bus_a.i_rdata = WD'(pa2) + WD'(100);
  assign bus_b.i_rdata = WD'(pb2) + WD'(100);

  logic [OW-1:0] outs_a, outs_b;
  assign outs_a = {bus_a.o_busy, bus_a.o_rden, bus_a.o_raddr, bus_a.o_vsync, bus_a.o_hsync,
                   bus_a.o_reuse, bus_a.o_valid, bus_a.o_done, bus_a.o_tdata};
  assign outs_b = {bus_b.o_busy, bus_b.o_rden, bus_b.o_raddr, bus_b.o_vsync, bus_b.o_hsync,
                   bus_b.o_reuse, bus_b.o_valid, bus_b.o_done, bus_b.o_tdata};

  // Monitored DUT selected by sel
  logic          m_busy, m_rden, m_vsync, m_hsync, m_reuse, m_valid, m_done;
  logic [AW-1:0] m_raddr;
  logic [WD-1:0] m_tdata;
  assign m_busy  = (sel != 0) ? bus_b.o_busy  : bus_a.o_busy;
  assign m_rden  = (sel != 0) ? bus_b.o_rden  : bus_a.o_rden;
  assign m_raddr = (sel != 0) ? bus_b.o_raddr : bus_a.o_raddr;
  assign m_vsync = (sel != 0) ? bus_b.o_vsync : bus_a.o_vsync;
  assign m_hsync = (sel != 0) ? bus_b.o_hsync : bus_a.o_hsync;
  assign m_reuse = (sel != 0) ? bus_b.o_reuse : bus_a.o_reuse;
  assign m_valid = (sel != 0) ? bus_b.o_valid : bus_a.o_valid;
  assign m_done  = (sel != 0) ? bus_b.o_done  : bus_a.o_done;
  assign m_tdata = (sel != 0) ? bus_b.o_tdata : bus_a.o_tdata;

  task automatic set_start(input int s, input logic v);
    if (s != 0) bus_b.i_start = v;
    else        bus_a.i_start = v;
  endtask

  // Start one run on DUT s and compare every cycle against the frame model.
  task automatic run_and_check(input int s, input int rep, input bit noise, input string name);
    int gap_c, pw, n, rowlen, f, t_last, total, nbad, u, p, q, r, k, fi, addr, valid_ct;
    bit e_rden, e_vs, e_hs, e_va, e_re, e_dn, e_busy, in_frame, pulsed;
    logic [AW-1:0] e_raddr;
    logic [WD-1:0] e_tdata;
    logic [OW-1:0] got, exp;
    gap_c  = (s != 0) ? GAPB : GAPA;
    pw     = (s != 0) ? PWB : PWA;
    n      = (rep == 0) ? 1 : rep;
    rowlen = 1 + S*C + gap_c;
    f      = VL + pw + S*rowlen;
    t_last = n*f - 1 - gap_c;           // read-issue cycle of the final beat
    total  = n*f + RL + 3;
    nbad   = 0;
    valid_ct = 0;
    pulsed = 1'b0;
    sel    = s;
    @(negedge clk);
    if (s != 0) bus_b.i_repeat = 8'(rep);
    else        bus_a.i_repeat = 8'(rep);
    set_start(s, 1'b1);
    @(negedge clk);
    set_start(s, 1'b0);
    for (int t = 0; t < total; t++) begin
      if (t > 0) @(negedge clk);
      if (pulsed) begin
        set_start(s, 1'b0);
        pulsed = 1'b0;
      end
      // read side: issue-time position
      e_rden = 1'b0; e_raddr = '0;
      if (t < n*f) begin
        p = t % f; q = p - VL - pw;
        if (q >= 0) begin
          r = q / rowlen; k = q % rowlen;
          if (k >= 1 && k <= S*C) begin
            e_rden  = 1'b1;
            e_raddr = AW'(r*S*C + k - 1);
          end
        end
      end
      // stream side: same position, RL+1 cycles later
      u = t - (RL + 1);
      in_frame = (u >= 0) && (u < n*f);
      e_vs = 1'b0; e_hs = 1'b0; e_va = 1'b0; e_tdata = '0;
      fi = 0;
      if (in_frame) begin
        fi = u / f; p = u % f; q = p - VL - pw;
        e_vs = (p < VL);
        if (q >= 0) begin
          r = q / rowlen; k = q % rowlen;
          e_hs = (k == 0);
          if (k >= 1 && k <= S*C) begin
            e_va    = 1'b1;
            addr    = r*S*C + k - 1;
            e_tdata = WD'(addr + 100);
          end
        end
      end
      e_re   = in_frame && (fi >= 1) && (u <= t_last);
      e_dn   = (u == t_last);
      e_busy = (t <= t_last + RL + 1);
      got = {m_busy, m_rden, (e_rden ? m_raddr : AW'(0)), m_vsync, m_hsync,
             m_reuse, m_valid, m_done, m_tdata};
      exp = {e_busy, e_rden, e_raddr, e_vs, e_hs, e_re, e_va, e_dn, e_tdata};
      if (m_valid) valid_ct++;
      checks++;
      if (got !== exp) begin
        failures++;
        nbad++;
        $display("FAIL %s cycle=%0d got=%h expected=%h", name, t, got, exp);
      end
      if (noise && t >= 1 && t <= n*f - 2 && $urandom_range(0, 5) == 0) begin
        set_start(s, 1'b1);
        pulsed = 1'b1;
      end
    end
    set_start(s, 1'b0);
    checks++;
    if (valid_ct !== n*S*S*C) begin
      failures++;
      $display("FAIL %s_beats got=%0d expected=%0d", name, valid_ct, n*S*S*C);
    end
    $display("%s: dut=%0d repeat=%0d frames=%0d cycles=%0d beats=%0d bad_cycles=%0d",
             name, s, rep, n, total, valid_ct, nbad);
  endtask

  task automatic test_reset();
    bus_a.i_start = 1'b0; bus_a.i_repeat = '0;
    bus_b.i_start = 1'b0; bus_b.i_repeat = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (outs_a !== '0) begin
      failures++;
      $display("FAIL reset_a got=%h expected=0", outs_a);
    end
    checks++;
    if (outs_b !== '0) begin
      failures++;
      $display("FAIL reset_b got=%h expected=0", outs_b);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("reset: outputs a=%h b=%h", outs_a, outs_b);
  endtask

  task automatic test_single_frame();
    run_and_check(0, 1, 1'b0, "single_frame");
  endtask

  task automatic test_repeat();
    run_and_check(0, 3, 1'b0, "repeat3");
  endtask

  task automatic test_repeat_zero();
    run_and_check(0, 0, 1'b0, "repeat0");
  endtask

  task automatic test_start_ignored();
    run_and_check(0, 1, 1'b1, "start_ignored");
    run_and_check(0, 2, 1'b1, "start_ignored2");
  endtask

  task automatic test_no_gap();
    run_and_check(1, 1, 1'b0, "no_gap");
    run_and_check(1, 2, 1'b1, "no_gap_rep2");
  endtask

  task automatic test_random();
    int rep, s, idle;
    for (int i = 0; i < 4; i++) begin
      rep  = int'($urandom_range(0, 3));
      s    = int'($urandom_range(0, 1));
      idle = int'($urandom_range(0, 5));
      repeat (idle) @(negedge clk);
      run_and_check(s, rep, 1'(($urandom_range(0, 1))), "random");
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    sel = 0;
    @(negedge clk);
    bus_a.i_repeat = 8'd1;
    bus_a.i_start  = 1'b1;
    @(negedge clk);
    bus_a.i_start  = 1'b0;
    // land inside the second row's output beats
    repeat (RL + 1 + VL + PWA + (1 + S*C + GAPA) + 3) @(negedge clk);
    checks++;
    if (bus_a.o_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_row_valid got=%b expected=1", bus_a.o_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (outs_a !== '0) begin
      failures++;
      $display("FAIL async_reset got=%h expected=0", outs_a);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (bus_a.o_valid || bus_a.o_done || bus_a.o_busy || bus_a.o_vsync || bus_a.o_rden) stray++;
    end
    checks++;
    if (stray !== 0) begin
      failures++;
      $display("FAIL after_reset_activity got=%0d expected=0", stray);
    end
    $display("reset_mid: stray_cycles=%0d", stray);
    run_and_check(0, 1, 1'b0, "post_reset_frame");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_repeat();
    test_repeat_zero();
    test_start_ignored();
    test_no_gap();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
